mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Bus initiator for the 16-bit x 4K zero-delay-read RAM interface: address, read, write, writedata and readdata.
- Executes one command at a time: a block copy from a source region to a destination region, or a block fill with a constant.
- Sits beside the MU0 core as a simple DMA. It connects to a RAM port through the same signal set the core uses.
- Relies on the RAM's combinational read: readdata is valid in the same cycle that read and address are driven.

Parameters:
- ADDR_W, 12, memory address width. All address arithmetic is modulo 2^ADDR_W.
- DATA_W, 16, memory word width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- start  input  1  command strobe. Sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  ADDR_W  copy source base address. Ignored in fill mode.
- dst_addr  input  ADDR_W  destination base address.
- length  input  ADDR_W+1  number of words, 0..4096.
- fill_value  input  DATA_W  fill word. Ignored in copy mode.
- busy  output  1  high while a command is executing.
- done  output  1  one-cycle completion pulse.
- address  output  ADDR_W  memory address.
- read  output  1  memory read enable.
- write  output  1  memory write enable. The RAM commits the write at the clk edge ending the cycle.
- writedata  output  DATA_W  memory write data.
- readdata  input  DATA_W  memory read data, combinational from address and read.

Behaviour:
- Reset (reset_n low at a rising clk edge):
  - State goes to IDLE.
  - busy, done, read and write all go to 0; address and writedata go to 0.
  - Internal counters and registers are cleared.
- Reset mid-operation: the command is abandoned at that edge. There are no further read or write cycles and no done pulse. RAM writes already committed remain.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - read = 0, write = 0, busy = 0.
  - start = 1 at edge N captures src_addr, dst_addr, length, mode and fill_value into registers.
  - If length = 0, go to FIN.
  - Otherwise go to WR if mode = 1, or RD if mode = 0.
- RD (copy only):
  - read = 1, address = src pointer, busy = 1.
  - At the end of the cycle: readdata is latched into the data register, the src pointer increments, and the state goes to WR.
- WR:
  - write = 1, address = dst pointer, busy = 1.
  - writedata = data register in copy mode, or fill_value register in fill mode.
  - At the end of the cycle: the dst pointer increments and the remaining count decrements.
  - If the remaining count becomes 0, go to FIN.
  - Otherwise go to RD (copy) or stay in WR (fill).
- FIN:
  - done = 1 and busy = 0 for exactly one cycle, then go to IDLE.
  - A new start is accepted from the IDLE cycle after FIN.
- read and write are never both 1. Both are 0 in IDLE and FIN.
- Throughput:
  - Copy takes 2 cycles per word. busy is high for 2*length cycles, starting at cycle N+1.
  - Fill takes 1 cycle per word. busy is high for length cycles.
  - done is asserted in the cycle immediately after the last WR cycle.
- length = 0: busy never rises, no memory access occurs, and done pulses at cycle N+1.
- length = 4096: the full memory is covered. The 13-bit counter handles 4096 without overflow.
- Wrap-around: pointers increment modulo 4096, so address 0xFFF is followed by 0x000.
- Overlapping regions: no special handling. The copy is strictly ascending and word-by-word.
- start asserted while not in IDLE is ignored. The command inputs are not re-sampled.
- Command inputs may change freely after the start edge.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_W-1:0].
  - checksum is the modulo-2^16 sum of every word driven on writedata during WR cycles of the current command.
  - It is cleared to 0 on reset and on an accepted start.
  - It is stable and valid from the done cycle until the next accepted start.
- Not defined: the checksum port and its logic are absent. All other behaviour is identical.

Test Plan:
- Copy 4 words: RAM[0x010..0x013] = 1,2,3,4; start with mode = 0, src = 0x010, dst = 0x100, length = 4.
  -> RAM[0x100..0x103] = 1,2,3,4; busy high for 8 cycles; done pulse at cycle N+9; read and write never both high; checksum = 0x000A.
- Fill: mode = 1, dst = 0x200, length = 3, fill_value = 0xBEEF.
  -> Three consecutive write cycles at 0x200, 0x201, 0x202; done at cycle N+4; RAM[0x203] unchanged.
- Zero length: start with length = 0.
  -> No read or write asserted; busy stays 0; done is high only at cycle N+1.
- Wrap-around: copy src = 0xFFE, dst = 0x7FF, length = 3, with RAM[0xFFE], RAM[0xFFF], RAM[0x000] = 0xA, 0xB, 0xC.
  -> RAM[0x7FF], RAM[0x800], RAM[0x801] = 0xA, 0xB, 0xC; the read address sequence is 0xFFE, 0xFFF, 0x000.
- Busy start ignored: assert start with new operands 2 cycles into a length-4 copy.
  -> The original command completes unchanged; there is exactly one done pulse; no second command runs.
- Reset mid-operation: drive reset_n low for 1 cycle after the second WR of a length-4 fill.
  -> All outputs are 0 at the next cycle; exactly 2 words are written; no done pulse; a new start then executes normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Single-command DMA for a 16-bit x 4K zero-delay-read RAM: block copy or constant fill.
// Optional MEM_COPY_CHECKSUM_EN adds a running sum of the words written by the current command.
module mem_copy_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W:0]   r_cnt;
    logic              r_mode;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_wdata;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    assign w_wdata = r_mode ? r_fill : r_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_fill  <= '0;
            r_data  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src  <= src_addr;
                        r_dst  <= dst_addr;
                        r_cnt  <= length;
                        r_mode <= mode;
                        r_fill <= fill_value;
`ifdef MEM_COPY_CHECKSUM_EN
                        r_sum  <= '0;
`endif
                        if (length == '0)
                            r_state <= S_FIN;
                        else if (mode)
                            r_state <= S_WR;
                        else
                            r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_data  <= readdata;
                    r_src   <= r_src + ADDR_W'(1);
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_dst <= r_dst + ADDR_W'(1);
                    r_cnt <= r_cnt - (ADDR_W + 1)'(1);
`ifdef MEM_COPY_CHECKSUM_EN
                    r_sum <= r_sum + w_wdata;
`endif
                    // r_cnt still holds the pre-decrement value here
                    if (r_cnt == (ADDR_W + 1)'(1))
                        r_state <= S_FIN;
                    else if (r_mode)
                        r_state <= S_WR;
                    else
                        r_state <= S_RD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus signals decode straight from state so reset idles the bus in the same edge
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        case (r_state)
            S_RD: begin
                busy    = 1'b1;
                read    = 1'b1;
                address = r_src;
            end
            S_WR: begin
                busy      = 1'b1;
                write     = 1'b1;
                address   = r_dst;
                writedata = w_wdata;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum = r_sum;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: RAM model, per-cycle expected bus trace and directed commands.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] src_addr = '0;
    logic [11:0] dst_addr = '0;
    logic [12:0] length = '0;
    logic [15:0] fill_value = '0;
    logic        busy, done, read, write;
    logic [11:0] address;
    logic [15:0] writedata, readdata;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .busy(busy), .done(done), .address(address),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata)
`ifdef MEM_COPY_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

`ifndef MEM_COPY_CHECKSUM_EN
    assign checksum = 16'h0;
`endif

    // RAM: combinational read, write committed at the clock edge
    logic [15:0] mem [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic        ram_init = 1'b0;
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    assign readdata = read ? mem[address] : 16'h0;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (write) begin
            mem[address] <= writedata;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [15:0] wd;
        logic [15:0] sum;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    // Per-cycle bus comparison; an empty queue means the engine must be idle
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (chk_en) begin
            e = '0;
            if (expq.size() > 0) e = expq.pop_front();
            checks++;
            if ({busy, done, read, write, address, writedata} !==
                {e.busy, e.done, e.rd, e.wr, e.addr, e.wd}) begin
                errors++;
                $display("FAIL bus cyc=%0d got b%0b d%0b r%0b w%0b a%03h wd%04h expected b%0b d%0b r%0b w%0b a%03h wd%04h",
                         cyc, busy, done, read, write, address, writedata,
                         e.busy, e.done, e.rd, e.wr, e.addr, e.wd);
            end
`ifdef MEM_COPY_CHECKSUM_EN
            if (e.done) begin
                checks++;
                if (checksum !== e.sum) begin
                    errors++;
                    $display("FAIL checksum cyc=%0d got %04h expected %04h", cyc, checksum, e.sum);
                end
            end
`endif
        end
    end

    // Model: expected trace of a command; limit < len models an abort after limit writes
    task automatic push_cmd(input bit m, input logic [11:0] s, input logic [11:0] d,
                            input int len, input logic [15:0] fv, input int limit);
        exp_t        e;
        logic [15:0] sum;
        logic [15:0] w;
        logic [11:0] a;
        sum = 16'h0;
        expq.push_back(exp_t'(0));
        for (int i = 0; i < limit; i++) begin
            if (!m) begin
                a = s + 12'(i);
                w = ref_mem[a];
                e = '0; e.busy = 1'b1; e.rd = 1'b1; e.addr = a;
                expq.push_back(e);
            end else begin
                w = fv;
            end
            a = d + 12'(i);
            e = '0; e.busy = 1'b1; e.wr = 1'b1; e.addr = a; e.wd = w;
            expq.push_back(e);
            ref_mem[a] = w;
            sum = sum + w;
        end
        if (limit == len) begin
            e = '0; e.done = 1'b1; e.sum = sum;
            expq.push_back(e);
        end
    endtask

    task automatic set_word(input logic [11:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = a; pl_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Returns at #1 after the start edge, i.e. inside cycle N+1
    task automatic launch(input bit m, input logic [11:0] s, input logic [11:0] d,
                          input int len, input logic [15:0] fv, input int limit);
        @(posedge clk); #1;
        push_cmd(m, s, d, len, fv, limit);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d;
        length = 13'(len); fill_value = fv;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom); src_addr = 12'($urandom); dst_addr = 12'($urandom);
        length = 13'($urandom); fill_value = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, output int dk, output int bc, output logic [15:0] cs);
        dk = -1; bc = 0; cs = 16'h0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dk = k;
                cs = checksum;
                break;
            end
        end
    endtask

    int          dk, bc;
    logic [15:0] cs;
    int          diffs;

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h1000 + 16'(i);
        reset_n = 1'b0;
        ram_init = 1'b1;
        @(posedge clk); #1;
        ram_init = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_outputs", {26'h0, busy, done, read, write, |address, |writedata}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Copy 4 words
        for (int i = 0; i < 4; i++) set_word(12'h010 + 12'(i), 16'(i + 1));
        launch(1'b0, 12'h010, 12'h100, 4, 16'h0, 4);
        wait_done(40, dk, bc, cs);
        chk("copy4_done_cycle", dk, 9);
        chk("copy4_busy_cycles", bc, 8);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("copy4_checksum", cs, 16'h000A);
`endif
        for (int i = 0; i < 4; i++) chk("copy4_ram", mem[12'h100 + 12'(i)], i + 1);

        // Fill 3 words
        launch(1'b1, 12'h000, 12'h200, 3, 16'hBEEF, 3);
        wait_done(40, dk, bc, cs);
        chk("fill3_done_cycle", dk, 4);
        chk("fill3_busy_cycles", bc, 3);
        chk("fill3_ram_200", mem[12'h200], 16'hBEEF);
        chk("fill3_ram_202", mem[12'h202], 16'hBEEF);
        chk("fill3_ram_203_untouched", mem[12'h203], 16'h1203);

        // Zero length
        launch(1'b0, 12'h123, 12'h456, 0, 16'h0, 0);
        wait_done(10, dk, bc, cs);
        chk("zero_done_cycle", dk, 1);
        chk("zero_busy_cycles", bc, 0);

        // Wrap-around copy
        set_word(12'hFFE, 16'h000A);
        set_word(12'hFFF, 16'h000B);
        set_word(12'h000, 16'h000C);
        launch(1'b0, 12'hFFE, 12'h7FF, 3, 16'h0, 3);
        wait_done(40, dk, bc, cs);
        chk("wrap_done_cycle", dk, 7);
        chk("wrap_ram_7ff", mem[12'h7FF], 16'h000A);
        chk("wrap_ram_800", mem[12'h800], 16'h000B);
        chk("wrap_ram_801", mem[12'h801], 16'h000C);

        // Start while busy is ignored
        launch(1'b0, 12'h010, 12'h300, 4, 16'h0, 4);
        fork
            wait_done(40, dk, bc, cs);
            begin
                @(posedge clk); #1;
                start = 1'b1; mode = 1'b1; dst_addr = 12'h400; length = 13'd2; fill_value = 16'hDEAD;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        chk("ignore_done_cycle", dk, 9);
        chk("ignore_ram_303", mem[12'h303], 16'h0004);
        repeat (4) @(posedge clk);
        #1;
        chk("ignore_ram_400_untouched", mem[12'h400], 16'h1400);

        // Reset after the second write of a fill
        launch(1'b1, 12'h000, 12'h500, 4, 16'h5555, 2);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("rst_ram_501", mem[12'h501], 16'h5555);
        chk("rst_ram_502_untouched", mem[12'h502], 16'h1502);
        chk("rst_queue_drained", expq.size(), 0);
        launch(1'b1, 12'h000, 12'h600, 2, 16'h7777, 2);
        wait_done(20, dk, bc, cs);
        chk("post_rst_done_cycle", dk, 3);

        @(posedge clk); #1;
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("ram_vs_model_a", diffs, 0);

        // Full-memory fill
        launch(1'b1, 12'h000, 12'h800, 4096, 16'h1234, 4096);
        wait_done(5000, dk, bc, cs);
        chk("full_done_cycle", dk, 4097);
        chk("full_busy_cycles", bc, 4096);
        @(posedge clk); #1;
        diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("ram_vs_model_b", diffs, 0);
        chk("full_ram_7ff", mem[12'h7FF], 16'h1234);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
